// File: rtl/nano_rv32i_pkg.sv
// rtl/nano_rv32i_pkg.sv - shared constants for the MMIO arbiter slice
package nano_rv32i_pkg;

  // Arbiter FSM state encoding
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR      = 3'd1;
  localparam logic [2:0] ST_WR_RESP = 3'd2;
  localparam logic [2:0] ST_RD      = 3'd3;
  localparam logic [2:0] ST_RD_RESP = 3'd4;
  localparam logic [2:0] ST_ACK     = 3'd5;

  // AXI response codes
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Anything other than OKAY is reported to the requester as an error
  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-way round-robin grant with registered last winner
module rr_arbiter_2 (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [1:0] req_i,
  input  logic       grant_en_i,
  output logic       grant_valid_o,
  output logic       grant_idx_o
);

  logic last_grant_q;

  // Single requester wins outright; on a tie the port that did not win last time goes
  always_comb begin
    grant_valid_o = |req_i;
    grant_idx_o   = 1'b0;
    case (req_i)
      2'b01:   grant_idx_o = 1'b0;
      2'b10:   grant_idx_o = 1'b1;
      2'b11:   grant_idx_o = ~last_grant_q;
      default: grant_idx_o = 1'b0;
    endcase
  end

  // Remember the winner; reset to 1 so port 0 wins the first tie
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      last_grant_q <= 1'b1;
    end else if (grant_en_i && grant_valid_o) begin
      last_grant_q <= grant_idx_o;
    end
  end

endmodule

// File: rtl/axil_mmio_arbiter.sv
// rtl/axil_mmio_arbiter.sv - shares one AXI-Lite MMIO master between two req/ack ports
module axil_mmio_arbiter
  import nano_rv32i_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [31:0]       m0_wdata_i,
  input  logic [3:0]        m0_wstrb_i,
  output logic              m0_ack_o,
  output logic [31:0]       m0_rdata_o,
  output logic              m0_err_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [31:0]       m1_wdata_i,
  input  logic [3:0]        m1_wstrb_i,
  output logic              m1_ack_o,
  output logic [31:0]       m1_rdata_o,
  output logic              m1_err_o,
  output logic [ADDR_W-1:0] s_axi_awaddr_o,
  output logic              s_axi_awvalid_o,
  input  logic              s_axi_awready_i,
  output logic [31:0]       s_axi_wdata_o,
  output logic [3:0]        s_axi_wstrb_o,
  output logic              s_axi_wvalid_o,
  input  logic              s_axi_wready_i,
  input  logic [1:0]        s_axi_bresp_i,
  input  logic              s_axi_bvalid_i,
  output logic              s_axi_bready_o,
  output logic [ADDR_W-1:0] s_axi_araddr_o,
  output logic              s_axi_arvalid_o,
  input  logic              s_axi_arready_i,
  input  logic [31:0]       s_axi_rdata_i,
  input  logic [1:0]        s_axi_rresp_i,
  input  logic              s_axi_rvalid_i,
  output logic              s_axi_rready_o
);

  // Ack is registered, so the forced completion is taken one cycle early to land
  // the ack exactly TIMEOUT_CYCLES cycles after the grant cycle
  localparam logic [16:0] TO_LIM = 17'(TIMEOUT_CYCLES);

  logic [2:0]        state_q;
  logic              gnt_q;
  logic              aw_done_q;
  logic              w_done_q;
  logic [15:0]       cnt_q;

  logic              grant_valid;
  logic              grant_idx;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [3:0]        sel_wstrb;

  logic              aw_hs;
  logic              w_hs;
  logic              ar_hs;
  logic              wr_both_done;
  logic              busy;
  logic              timeout_hit;

  logic              comp;
  logic              comp_err;
  logic              comp_rd;
  logic [31:0]       comp_rdata;

  rr_arbiter_2 u_rr (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .req_i         ({m1_req_i, m0_req_i}),
    .grant_en_i    (state_q == ST_IDLE),
    .grant_valid_o (grant_valid),
    .grant_idx_o   (grant_idx)
  );

  // Route the winning requester's command fields toward the latches
  always_comb begin
    sel_we    = grant_idx ? m1_we_i    : m0_we_i;
    sel_addr  = grant_idx ? m1_addr_i  : m0_addr_i;
    sel_wdata = grant_idx ? m1_wdata_i : m0_wdata_i;
    sel_wstrb = grant_idx ? m1_wstrb_i : m0_wstrb_i;
  end

  // Handshake and watchdog status for the current transaction
  always_comb begin
    aw_hs        = s_axi_awvalid_o && s_axi_awready_i;
    w_hs         = s_axi_wvalid_o && s_axi_wready_i;
    ar_hs        = s_axi_arvalid_o && s_axi_arready_i;
    wr_both_done = (aw_done_q || aw_hs) && (w_done_q || w_hs);
    busy         = (state_q == ST_WR) || (state_q == ST_WR_RESP) ||
                   (state_q == ST_RD) || (state_q == ST_RD_RESP);
    timeout_hit  = busy && (({1'b0, cnt_q} + 17'd2) >= TO_LIM);
  end

  // Decide whether this cycle ends the transaction; a real response beats the watchdog
  always_comb begin
    comp       = 1'b0;
    comp_err   = 1'b0;
    comp_rd    = 1'b0;
    comp_rdata = 32'h0;
    case (state_q)
      ST_WR: begin
        if (!wr_both_done && timeout_hit) begin
          comp     = 1'b1;
          comp_err = 1'b1;
        end
      end
      ST_WR_RESP: begin
        if (s_axi_bvalid_i) begin
          comp     = 1'b1;
          comp_err = resp_is_err(s_axi_bresp_i);
        end else if (timeout_hit) begin
          comp     = 1'b1;
          comp_err = 1'b1;
        end
      end
      ST_RD: begin
        if (!ar_hs && timeout_hit) begin
          comp     = 1'b1;
          comp_err = 1'b1;
          comp_rd  = 1'b1;
        end
      end
      ST_RD_RESP: begin
        if (s_axi_rvalid_i) begin
          comp       = 1'b1;
          comp_err   = resp_is_err(s_axi_rresp_i);
          comp_rd    = 1'b1;
          comp_rdata = s_axi_rdata_i;
        end else if (timeout_hit) begin
          comp     = 1'b1;
          comp_err = 1'b1;
          comp_rd  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Transaction FSM: grant, drive AXI channels, collect response, pulse ack
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q         <= ST_IDLE;
      gnt_q           <= 1'b0;
      aw_done_q       <= 1'b0;
      w_done_q        <= 1'b0;
      cnt_q           <= 16'h0;
      m0_ack_o        <= 1'b0;
      m0_rdata_o      <= 32'h0;
      m0_err_o        <= 1'b0;
      m1_ack_o        <= 1'b0;
      m1_rdata_o      <= 32'h0;
      m1_err_o        <= 1'b0;
      s_axi_awaddr_o  <= '0;
      s_axi_awvalid_o <= 1'b0;
      s_axi_wdata_o   <= 32'h0;
      s_axi_wstrb_o   <= 4'h0;
      s_axi_wvalid_o  <= 1'b0;
      s_axi_bready_o  <= 1'b0;
      s_axi_araddr_o  <= '0;
      s_axi_arvalid_o <= 1'b0;
      s_axi_rready_o  <= 1'b0;
    end else begin
      m0_ack_o <= 1'b0;
      m1_ack_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (grant_valid) begin
            gnt_q     <= grant_idx;
            cnt_q     <= 16'h0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            if (sel_we) begin
              s_axi_awaddr_o  <= sel_addr;
              s_axi_wdata_o   <= sel_wdata;
              s_axi_wstrb_o   <= sel_wstrb;
              s_axi_awvalid_o <= 1'b1;
              s_axi_wvalid_o  <= 1'b1;
              state_q         <= ST_WR;
            end else begin
              s_axi_araddr_o  <= sel_addr;
              s_axi_arvalid_o <= 1'b1;
              state_q         <= ST_RD;
            end
          end
        end
        ST_WR: begin
          cnt_q <= cnt_q + 16'd1;
          if (aw_hs) begin
            s_axi_awvalid_o <= 1'b0;
            aw_done_q       <= 1'b1;
          end
          if (w_hs) begin
            s_axi_wvalid_o <= 1'b0;
            w_done_q       <= 1'b1;
          end
          if (wr_both_done) begin
            s_axi_bready_o <= 1'b1;
            state_q        <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          cnt_q <= cnt_q + 16'd1;
        end
        ST_RD: begin
          cnt_q <= cnt_q + 16'd1;
          if (ar_hs) begin
            s_axi_arvalid_o <= 1'b0;
            s_axi_rready_o  <= 1'b1;
            state_q         <= ST_RD_RESP;
          end
        end
        ST_RD_RESP: begin
          cnt_q <= cnt_q + 16'd1;
        end
        ST_ACK: begin
          m0_err_o <= 1'b0;
          m1_err_o <= 1'b0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase

      if (comp) begin
        state_q         <= ST_ACK;
        s_axi_awvalid_o <= 1'b0;
        s_axi_wvalid_o  <= 1'b0;
        s_axi_bready_o  <= 1'b0;
        s_axi_arvalid_o <= 1'b0;
        s_axi_rready_o  <= 1'b0;
        if (gnt_q) begin
          m1_ack_o <= 1'b1;
          m1_err_o <= comp_err;
          if (comp_rd) m1_rdata_o <= comp_rdata;
        end else begin
          m0_ack_o <= 1'b1;
          m0_err_o <= comp_err;
          if (comp_rd) m0_rdata_o <= comp_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_axil_mmio_arbiter.sv
// tb/tb_axil_mmio_arbiter.sv - directed self-checking bench for axil_mmio_arbiter
module tb_axil_mmio_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int          n_checks = 0;
  int          n_errs   = 0;
  int          cyc      = 0;
  int          t0       = 0;

  int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic        b_never  = 1'b0;
  logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
  logic [31:0] cfg_rdata = 32'h0;
  int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
  int          ar_cycles = 0;
  int          m1_acks = 0;
  logic [31:0] rec_awaddr = 32'h0, rec_wdata = 32'h0, rec_araddr = 32'h0;
  logic [3:0]  rec_wstrb = 4'h0;

  axil_mmio_arbiter #(.ADDR_W(32), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_wstrb_i(m0_wstrb), .m0_ack_o(m0_ack_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_wstrb_i(m1_wstrb), .m1_ack_o(m1_ack_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
    .s_axi_awaddr_o(awaddr), .s_axi_awvalid_o(awvalid), .s_axi_awready_i(awready),
    .s_axi_wdata_o(wdata), .s_axi_wstrb_o(wstrb), .s_axi_wvalid_o(wvalid), .s_axi_wready_i(wready),
    .s_axi_bresp_i(bresp), .s_axi_bvalid_i(bvalid), .s_axi_bready_o(bready),
    .s_axi_araddr_o(araddr), .s_axi_arvalid_o(arvalid), .s_axi_arready_i(arready),
    .s_axi_rdata_i(rdata), .s_axi_rresp_i(rresp), .s_axi_rvalid_i(rvalid), .s_axi_rready_o(rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Configurable AXI-Lite slave, driven on the falling edge
  always @(negedge clk) begin
    if (!rst_n) begin
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    end else begin
      awready = awvalid && (aw_cnt == aw_delay);
      aw_cnt  = awvalid ? aw_cnt + 1 : 0;
      if (awvalid && awready) rec_awaddr = awaddr;
      wready = wvalid && (w_cnt == w_delay);
      w_cnt  = wvalid ? w_cnt + 1 : 0;
      if (wvalid && wready) begin rec_wdata = wdata; rec_wstrb = wstrb; end
      arready = arvalid && (ar_cnt == ar_delay);
      ar_cnt  = arvalid ? ar_cnt + 1 : 0;
      if (arvalid) ar_cycles = ar_cycles + 1;
      if (arvalid && arready) rec_araddr = araddr;
      bvalid = bready && !b_never && (b_cnt >= b_delay);
      b_cnt  = bready ? b_cnt + 1 : 0;
      bresp  = cfg_bresp;
      rvalid = rready && (r_cnt >= r_delay);
      r_cnt  = rready ? r_cnt + 1 : 0;
      rresp  = cfg_rresp;
      rdata  = cfg_rdata;
    end
    if (m1_ack_o) m1_acks = m1_acks + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] ws);
    @(negedge clk);
    if (port == 0) begin
      m0_we = we; m0_addr = addr; m0_wdata = wd; m0_wstrb = ws; m0_req = 1'b1;
    end else begin
      m1_we = we; m1_addr = addr; m1_wdata = wd; m1_wstrb = ws; m1_req = 1'b1;
    end
    t0 = cyc;
  endtask

  task automatic wait_ack(input int port, output int lat, output logic [31:0] rd, output logic er);
    logic got;
    got = 1'b0; lat = -1; rd = 32'hx; er = 1'bx;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if ((port == 0) ? m0_ack_o : m1_ack_o) begin
        got = 1'b1;
        lat = cyc - t0;
        rd  = (port == 0) ? m0_rdata_o : m1_rdata_o;
        er  = (port == 0) ? m0_err_o : m1_err_o;
      end
    end
    chk("ack_seen", {31'h0, got}, 32'h1);
    if (port == 0) m0_req = 1'b0; else m1_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          lat, prev;
    logic [31:0] rd;
    logic        er;
    rst_n = 0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
    bresp = 0; rresp = 0; rdata = 0;
    repeat (3) @(negedge clk);
    chk("rst_awvalid", {31'h0, awvalid}, 0);
    chk("rst_arvalid", {31'h0, arvalid}, 0);
    chk("rst_bready", {31'h0, bready}, 0);
    chk("rst_acks", {30'h0, m1_ack_o, m0_ack_o}, 0);
    chk("rst_rdata", m0_rdata_o | m1_rdata_o, 0);
    rst_n = 1;

    // m0 zero-wait write
    issue(0, 1'b1, 32'h4000_0000, 32'hDEAD_BEEF, 4'hF);
    wait_ack(0, lat, rd, er);
    chk("wr_latency", lat, 3);
    chk("wr_err", {31'h0, er}, 0);
    chk("wr_awaddr", rec_awaddr, 32'h4000_0000);
    chk("wr_wdata", rec_wdata, 32'hDEAD_BEEF);
    chk("wr_wstrb", {28'h0, rec_wstrb}, 32'hF);
    repeat (2) @(negedge clk);
    chk("wr_m1_quiet", m1_acks, 0);

    // m1 read with arready delayed 4 cycles
    ar_delay = 4; cfg_rdata = 32'h0000_00A5; ar_cycles = 0;
    issue(1, 1'b0, 32'h4000_0008, 32'h0, 4'h0);
    wait_ack(1, lat, rd, er);
    chk("rd_rdata", rd, 32'h0000_00A5);
    chk("rd_err", {31'h0, er}, 0);
    chk("rd_ar_cycles", ar_cycles, 5);
    chk("rd_araddr", rec_araddr, 32'h4000_0008);
    chk("rd_latency", lat, 7);
    repeat (3) @(negedge clk);
    chk("rd_rdata_hold", m1_rdata_o, 32'h0000_00A5);
    ar_delay = 0;

    // write where W completes two cycles after AW
    w_delay = 2;
    issue(0, 1'b1, 32'h4000_0004, 32'h1234_5678, 4'h3);
    @(negedge clk);
    chk("aw1_valids", {30'h0, awvalid, wvalid}, 32'h3);
    @(negedge clk);
    chk("aw2_valids", {29'h0, awvalid, wvalid, bready}, 32'h2);
    @(negedge clk);
    chk("aw3_valids", {29'h0, awvalid, wvalid, bready}, 32'h2);
    @(negedge clk);
    chk("aw4_valids", {29'h0, awvalid, wvalid, bready}, 32'h1);
    wait_ack(0, lat, rd, er);
    chk("aw_latency", lat, 5);
    chk("aw_wstrb", {28'h0, rec_wstrb}, 32'h3);
    w_delay = 0;

    // read answered with SLVERR
    cfg_rresp = 2'b10; cfg_rdata = 32'h0000_1234;
    issue(0, 1'b0, 32'h4000_0010, 32'h0, 4'h0);
    wait_ack(0, lat, rd, er);
    chk("slverr_err", {31'h0, er}, 1);
    chk("slverr_latency", lat, 3);
    cfg_rresp = 2'b00;

    // write whose response never comes
    b_never = 1'b1;
    issue(1, 1'b1, 32'h4000_0020, 32'hCAFE_F00D, 4'hF);
    wait_ack(1, lat, rd, er);
    chk("to_wr_latency", lat, 16);
    chk("to_wr_err", {31'h0, er}, 1);
    @(negedge clk);
    chk("to_wr_bready", {31'h0, bready}, 0);
    b_never = 1'b0;

    // read whose data never comes returns zero
    r_delay = 100;
    issue(0, 1'b0, 32'h4000_0030, 32'h0, 4'h0);
    wait_ack(0, lat, rd, er);
    chk("to_rd_latency", lat, 16);
    chk("to_rd_err", {31'h0, er}, 1);
    chk("to_rd_rdata", rd, 32'h0);
    r_delay = 0;
    @(negedge clk);

    // both ports request from reset and keep re-requesting
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    m0_we = 1; m0_addr = 32'h4000_0040; m0_wdata = 32'h11; m0_wstrb = 4'hF;
    m1_we = 1; m1_addr = 32'h4000_0044; m1_wdata = 32'h22; m1_wstrb = 4'hF;
    m0_req = 1; m1_req = 1;
    prev = cyc;
    for (int k = 0; k < 4; k++) begin
      int who;
      who = -1;
      for (int i = 0; i < 50 && who < 0; i++) begin
        @(negedge clk);
        if (m0_ack_o) who = 0;
        else if (m1_ack_o) who = 1;
      end
      chk("rr_order", who, k % 2);
      chk("rr_gap", cyc - prev, (k == 0) ? 3 : 4);
      prev = cyc;
      if (k == 3) begin
        m0_req = 0; m1_req = 0;
      end else begin
        if (who == 0) m0_req = 0; else m1_req = 0;
        @(negedge clk);
        if (who == 0) m0_req = 1; else m1_req = 1;
      end
    end
    repeat (6) @(negedge clk);

    // asynchronous reset while waiting in RD_RESP
    r_delay = 50; m1_acks = 0;
    issue(1, 1'b0, 32'h4000_0050, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    chk("arst_rready_before", {31'h0, rready}, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_rready", {31'h0, rready}, 0);
    chk("arst_arvalid", {31'h0, arvalid}, 0);
    chk("arst_rdata", m1_rdata_o, 0);
    m1_req = 0;
    @(negedge clk);
    rst_n = 1; r_delay = 0; cfg_rdata = 32'h5A5A_0001;
    @(negedge clk);
    chk("arst_no_ack", m1_acks, 0);
    issue(1, 1'b0, 32'h4000_0054, 32'h0, 4'h0);
    wait_ack(1, lat, rd, er);
    chk("arst_next_latency", lat, 3);
    chk("arst_next_rdata", rd, 32'h5A5A_0001);
    chk("arst_next_err", {31'h0, er}, 0);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/axil_mmio_arbiter.md
Name: axil_mmio_arbiter

Overview:
Shares the core's single AXI-Lite MMIO master port (GPIO and peripherals) between two requesters. Port 0 is the core LSU MMIO path; port 1 is a secondary master such as a debug/loader. Each requester uses a simple req/ack interface. The block runs one AXI-Lite transaction at a time, with round-robin grant, response checking and a timeout watchdog.

Parameters:
ADDR_W, 32, AXI/requester address width
TIMEOUT_CYCLES, 255, max cycles from grant to response before forced error completion (1..2^16-1)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
m0_req_i  in  1  port 0 request, held until m0_ack_o
m0_we_i  in  1  port 0 write(1)/read(0)
m0_addr_i  in  ADDR_W  port 0 address
m0_wdata_i  in  32  port 0 write data
m0_wstrb_i  in  4  port 0 byte strobes
m0_ack_o  out  1  port 0 one-cycle completion pulse
m0_rdata_o  out  32  port 0 read data, valid with ack, held until next port-0 ack
m0_err_o  out  1  port 0 error, valid with ack
m1_req_i, m1_we_i, m1_addr_i, m1_wdata_i, m1_wstrb_i, m1_ack_o, m1_rdata_o, m1_err_o: same as port 0, for port 1
s_axi_awaddr_o  out  ADDR_W;  s_axi_awvalid_o  out  1;  s_axi_awready_i  in  1
s_axi_wdata_o  out  32;  s_axi_wstrb_o  out  4;  s_axi_wvalid_o  out  1;  s_axi_wready_i  in  1
s_axi_bresp_i  in  2;  s_axi_bvalid_i  in  1;  s_axi_bready_o  out  1
s_axi_araddr_o  out  ADDR_W;  s_axi_arvalid_o  out  1;  s_axi_arready_i  in  1
s_axi_rdata_i  in  32;  s_axi_rresp_i  in  2;  s_axi_rvalid_i  in  1;  s_axi_rready_o  out  1

Behaviour:
- Clock and reset: single clock clk_i; reset rst_n_i is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, last_grant=1 (port 0 wins the first tie), timeout counter 0.
- All outputs are registered.
- States: IDLE, WR, WR_RESP, RD, RD_RESP, ACK.
- IDLE:
  - Sample both req_i. If exactly one is high, grant it. If both are high, grant the port not equal to last_grant.
  - On grant: latch we/addr/wdata/wstrb of the winner and update last_grant.
  - Go to WR with awvalid=wvalid=1, or to RD with arvalid=1.
- WR:
  - Each of awvalid and wvalid drops in the cycle after its own handshake; the two are independent and either order is legal.
  - When both handshakes are done, go to WR_RESP with bready=1.
- WR_RESP: on bvalid, drop bready, set err = (bresp != OKAY), go to ACK.
- RD:
  - arvalid holds until arready.
  - Then go to RD_RESP with rready=1.
- RD_RESP: on rvalid, latch rdata to the granted port's rdata_o, set err = (rresp != OKAY), drop rready, go to ACK.
- ACK: the granted ack_o is high for exactly this cycle, with err_o; then IDLE.
- Requester rule: the requester drops req_i the cycle after ack; a req still high in IDLE is a new request.
- Latency: for a zero-wait slave (ready high on the first valid cycle, response valid on the first bready/rready cycle), ack occurs 3 cycles after the cycle where the request is granted.
- Address/data stability: AXI address/data outputs hold latched values from grant until ACK. Requester input changes after grant are ignored.
- Ungranted port: its req is held pending and is served at the next IDLE; round-robin guarantees it is served within one transaction.
- Timeout:
  - The counter clears at grant and increments in WR, WR_RESP, RD and RD_RESP.
  - On reaching TIMEOUT_CYCLES, deassert all valid/ready, go to ACK with err=1; a timed-out read returns rdata=0.
  - After a timeout, any late slave response is ignored.
- Asynchronous reset mid-transaction: everything returns to reset values immediately, with no ack issued.
- Write-data lane order: strobes pass through unmodified; no byte lane steering.

Decomposition:
- Shared package nano_rv32i_pkg:
  - state encoding constants;
  - AXI response constants OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.
- Sub-module rr_arbiter_2: combinational grant from req[1:0] and last_grant, plus a registered last_grant update on grant_en.
- The FSM, latches and timeout counter stay in the top module.

Test Plan:
- m0 write 0x4000_0000 / 0xDEAD_BEEF / wstrb 0xF, zero-wait slave, bresp=OKAY -> AW/W beats carry those values; m0_ack 3 cycles after grant; m0_err=0; m1_ack stays 0.
- m1 read 0x4000_0008, arready delayed 4 cycles, rvalid with rdata 0x0000_00A5 -> arvalid held 5 cycles; m1_rdata=0x0000_00A5 with m1_ack; value holds afterwards.
- m0 and m1 request simultaneously from reset, held and re-requested repeatedly -> grant order 0,1,0,1; neither port waits more than one transaction.
- Write with awready at cycle 1 and wready at cycle 3 (W after AW) -> each valid drops independently; bready rises only after both handshakes.
- Read with rresp=SLVERR -> ack with err=1; write where the slave never asserts bvalid, TIMEOUT_CYCLES=16 -> ack with err=1 exactly 16 cycles after grant, bready low afterwards.
- Assert rst_n_i low during RD_RESP -> outputs 0 asynchronously; after release, the next request completes normally.
